// File: rtl/alu_pkg.sv
// Shared ALU datapath types: adder opcode encoding and its decode into
// operand-B inversion and carry-in selection.
package alu_pkg;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    ADC = 2'd1,
    SUB = 2'd2,
    SBB = 2'd3
  } add_op_t;

  typedef struct packed {
    logic invert_b;
    logic carry_in;
  } op_ctrl_t;

  function automatic op_ctrl_t decode_op(input add_op_t op, input logic cin);
    op_ctrl_t ctrl;
    ctrl = '0;
    case (op)
      ADD:     ctrl = '{invert_b: 1'b0, carry_in: 1'b0};
      ADC:     ctrl = '{invert_b: 1'b0, carry_in: cin};
      SUB:     ctrl = '{invert_b: 1'b1, carry_in: 1'b1};
      SBB:     ctrl = '{invert_b: 1'b1, carry_in: cin};
      default: ctrl = '0;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/cla_segment.sv
// Combinational SEG-bit carry-lookahead slice: NAND-level generate/propagate,
// full lookahead inside each GROUP, group carries rippled across the slice.
module cla_segment #(
  parameter int SEG       = 8,
  parameter int GROUP     = 4,
  parameter int NAND_TIME = 7
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           c_msb_in
);

  localparam int NGROUPS = SEG / GROUP;

  if (SEG % GROUP != 0) begin : g_bad_group
    $error("cla_segment: GROUP (%0d) must divide SEG (%0d)", GROUP, SEG);
  end
  // Gate delays are a simulation-model property; the RTL stays zero-delay.
  if (NAND_TIME < 0) begin : g_bad_delay
    $error("cla_segment: NAND_TIME must be non-negative");
  end

  logic [SEG-1:0] nand_ab;
  logic [SEG-1:0] g;
  logic [SEG-1:0] p;
  logic [SEG:0]   c;

  assign nand_ab = ~(a & b);
  assign g       = ~nand_ab;
  assign p       = ~(~(a & nand_ab) & ~(b & nand_ab));

  // Each bit carry comes from the group prefix (G,P) and the group carry-in,
  // never from the neighbouring bit carry.
  always_comb begin
    logic gp;
    logic pp;
    logic cg;
    c  = '0;
    gp = 1'b0;
    pp = 1'b1;
    cg = ci;
    c[0] = ci;
    for (int grp = 0; grp < NGROUPS; grp++) begin
      gp = 1'b0;
      pp = 1'b1;
      for (int j = 0; j < GROUP; j++) begin
        gp = g[grp*GROUP+j] | (p[grp*GROUP+j] & gp);
        pp = p[grp*GROUP+j] & pp;
        c[grp*GROUP+j+1] = gp | (pp & cg);
      end
      cg = gp | (pp & cg);
    end
  end

  assign s        = p ^ c[SEG-1:0];
  assign co       = c[SEG];
  assign c_msb_in = c[SEG-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined add/subtract unit: one SEG-bit lookahead slice resolved per stage,
// carry registered between stages, operands and partial sums carried alongside.
module pipelined_cla_adder
  import alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int STAGES    = 4,
  parameter int GROUP     = 4,
  parameter int NAND_TIME = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  add_op_t          op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SEG = WIDTH / STAGES;

  if (WIDTH % STAGES != 0) begin : g_bad_width
    $error("pipelined_cla_adder: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
  end

  op_ctrl_t         ctrl;
  logic [WIDTH-1:0] b_eff;
  logic             adv;

  // Per-stage inputs: stage 0 sees the ports, stage k sees register set k-1.
  logic [WIDTH-1:0] stg_a     [STAGES];
  logic [WIDTH-1:0] stg_b     [STAGES];
  logic [WIDTH-1:0] stg_sum   [STAGES];
  logic             stg_c     [STAGES];
  logic             stg_valid [STAGES];

  logic [SEG-1:0]   seg_s     [STAGES];
  logic             seg_co    [STAGES];
  logic             seg_cmsb  [STAGES];

  logic [WIDTH-1:0] a_q [STAGES], a_d [STAGES];
  logic [WIDTH-1:0] b_q [STAGES], b_d [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES], sum_d [STAGES];
  logic             carry_q [STAGES], carry_d [STAGES];
  logic             valid_q [STAGES], valid_d [STAGES];
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  assign ctrl     = decode_op(op, cin);
  assign b_eff    = ctrl.invert_b ? ~b : b;
  assign out_valid = valid_q[STAGES-1];
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign stg_a[k]     = a;
      assign stg_b[k]     = b_eff;
      assign stg_sum[k]   = '0;
      assign stg_c[k]     = ctrl.carry_in;
      assign stg_valid[k] = in_valid;
    end else begin : g_rest
      assign stg_a[k]     = a_q[k-1];
      assign stg_b[k]     = b_q[k-1];
      assign stg_sum[k]   = sum_q[k-1];
      assign stg_c[k]     = carry_q[k-1];
      assign stg_valid[k] = valid_q[k-1];
    end

    cla_segment #(
      .SEG       (SEG),
      .GROUP     (GROUP),
      .NAND_TIME (NAND_TIME)
    ) u_seg (
      .a        (stg_a[k][k*SEG +: SEG]),
      .b        (stg_b[k][k*SEG +: SEG]),
      .ci       (stg_c[k]),
      .s        (seg_s[k]),
      .co       (seg_co[k]),
      .c_msb_in (seg_cmsb[k])
    );
  end

  always_comb begin
    // NOTE: every _d defaults to its _q, so a stall holds state and no latch is inferred.
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        a_d[k]                 = stg_a[k];
        b_d[k]                 = stg_b[k];
        sum_d[k]               = stg_sum[k];
        sum_d[k][k*SEG +: SEG] = seg_s[k];
        carry_d[k]             = seg_co[k];
        valid_d[k]             = stg_valid[k];
      end
      ovf_d  = seg_co[STAGES-1] ^ seg_cmsb[STAGES-1];
      zero_d = (sum_d[STAGES-1] == '0);
    end
  end

  // NOTE: stage arrays are small flop banks, not RAM, so clearing them on reset is cheap and keeps outputs at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
        carry_q[k] <= 1'b0;
        valid_q[k] <= 1'b0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every stage samples the pre-edge value of its predecessor.
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign sum  = sum_q[STAGES-1];
  assign cout = carry_q[STAGES-1];
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder (WIDTH=32, STAGES=4): directed corner
// cases, back-to-back stream, output stall and mid-stream reset.
module tb_pipelined_cla_adder;
  import alu_pkg::*;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] a, b, sum;
  add_op_t          op;
  logic             cin, cout, ovf, zero;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
  } exp_t;

  exp_t sb[$];
  exp_t ex;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipelined_cla_adder #(.WIDTH(WIDTH), .STAGES(STAGES), .GROUP(4), .NAND_TIME(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  // Reference: plain (WIDTH+1)-bit arithmetic with the signed-overflow sign rule.
  function automatic exp_t model(input logic [WIDTH-1:0] fa, input logic [WIDTH-1:0] fb,
                                 input add_op_t fop, input logic fcin);
    logic [WIDTH-1:0] bb;
    logic             ci;
    logic [WIDTH:0]   full;
    exp_t             e;
    bb     = (fop == SUB || fop == SBB) ? ~fb : fb;
    ci     = (fop == ADD) ? 1'b0 : (fop == SUB) ? 1'b1 : fcin;
    full   = {1'b0, fa} + {1'b0, bb} + {{WIDTH{1'b0}}, ci};
    e.sum  = full[WIDTH-1:0];
    e.cout = full[WIDTH];
    e.ovf  = (fa[WIDTH-1] == bb[WIDTH-1]) && (e.sum[WIDTH-1] != fa[WIDTH-1]);
    e.zero = (e.sum == '0);
    return e;
  endfunction

  task automatic present(input logic v, input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                         input add_op_t xop, input logic xc, input logic ordy);
    in_valid  = v;
    a         = xa;
    b         = xb;
    op        = xop;
    cin       = xc;
    out_ready = ordy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    present(1'b0, '0, '0, ADD, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (sum !== '0) begin bad++; $display("FAIL reset_sum: got %h want 0", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout: got %b want 0", cout); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    total++; if (zero !== 1'b0) begin bad++; $display("FAIL reset_zero: got %b want 0", zero); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] da [4];
    logic [WIDTH-1:0] db [4];
    add_op_t          dop [4];
    logic             dc [4];
    exp_t             dexp [4];
    int               lat;
    da[0] = 32'hFFFF_FFFF; db[0] = 32'h0000_0001; dop[0] = ADD; dc[0] = 1'b0;
    da[1] = 32'h8000_0000; db[1] = 32'h0000_0001; dop[1] = SUB; dc[1] = 1'b0;
    da[2] = 32'h7FFF_FFFF; db[2] = 32'h0000_0000; dop[2] = ADC; dc[2] = 1'b1;
    da[3] = 32'h0000_0005; db[3] = 32'h0000_0005; dop[3] = SBB; dc[3] = 1'b0;
    dexp[0] = '{sum: 32'h0000_0000, cout: 1'b1, ovf: 1'b0, zero: 1'b1};
    dexp[1] = '{sum: 32'h7FFF_FFFF, cout: 1'b1, ovf: 1'b1, zero: 1'b0};
    dexp[2] = '{sum: 32'h8000_0000, cout: 1'b0, ovf: 1'b1, zero: 1'b0};
    dexp[3] = '{sum: 32'hFFFF_FFFF, cout: 1'b0, ovf: 1'b0, zero: 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      present(1'b1, da[i], db[i], dop[i], dc[i], 1'b1);
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL dir%0d_accept: in_ready=%b want 1", i, in_ready); end
      else sb.push_back(dexp[i]);
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
        present(1'b0, '0, '0, ADD, 1'b0, 1'b1);
        #1;
      end while (!out_valid && lat < 20);
      total++;
      if (lat != STAGES) begin bad++; $display("FAIL dir%0d_latency: got %0d cycles want %0d", i, lat, STAGES); end
      if (out_valid && out_ready && sb.size() > 0) begin
        ex = sb.pop_front();
        total++;
        if ({sum, cout, ovf, zero} !== {ex.sum, ex.cout, ex.ovf, ex.zero}) begin
          bad++;
          $display("FAIL dir%0d_result: got sum=%h c=%b v=%b z=%b want sum=%h c=%b v=%b z=%b",
                   i, sum, cout, ovf, zero, ex.sum, ex.cout, ex.ovf, ex.zero);
        end
      end
    end
    sb.delete();
  endtask

  task automatic test_back_to_back();
    int first_out = -1;
    int last_out  = -1;
    int n_out     = 0;
    for (int c = 0; c < 8 + STAGES + 4; c++) begin
      @(negedge clk);
      if (c < 8) present(1'b1, $urandom, (c == 0) ? 32'hFFFF_FFFF : $urandom,
                         add_op_t'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
      else       present(1'b0, '0, '0, ADD, 1'b0, 1'b1);
      #1;
      if (in_valid && in_ready) sb.push_back(model(a, b, op, cin));
      if (out_valid && out_ready) begin
        if (first_out < 0) first_out = c;
        last_out = c;
        n_out++;
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL b2b_extra: unexpected result sum=%h", sum); end
        else begin
          ex = sb.pop_front();
          if ({sum, cout, ovf, zero} !== {ex.sum, ex.cout, ex.ovf, ex.zero}) begin
            bad++;
            $display("FAIL b2b_result%0d: got sum=%h c=%b v=%b z=%b want sum=%h c=%b v=%b z=%b",
                     n_out, sum, cout, ovf, zero, ex.sum, ex.cout, ex.ovf, ex.zero);
          end
        end
      end
    end
    total++; if (n_out != 8) begin bad++; $display("FAIL b2b_count: got %0d results want 8", n_out); end
    total++; if (first_out != STAGES) begin bad++; $display("FAIL b2b_first: first result at cycle %0d want %0d", first_out, STAGES); end
    total++; if (last_out - first_out != 7) begin bad++; $display("FAIL b2b_consecutive: span %0d want 7", last_out - first_out); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL b2b_leftover: %0d expected results never seen", sb.size()); end
    sb.delete();
  endtask

  task automatic test_stall();
    logic [WIDTH-1:0] pa = $urandom;
    logic [WIDTH-1:0] pb = $urandom;
    add_op_t          po = add_op_t'($urandom_range(0, 3));
    logic             pc = 1'($urandom_range(0, 1));
    int sent = 0;
    int n_out = 0;
    int stalls = 0;
    for (int c = 0; c < 40 && (sent < 10 || sb.size() != 0); c++) begin
      @(negedge clk);
      present(sent < 10, pa, pb, po, pc, !(c >= 4 && c < 7));
      #1;
      if (out_valid && !out_ready) begin
        stalls++;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
        if (sb.size() > 0) begin
          total++;
          if ({sum, cout, ovf, zero} !== {sb[0].sum, sb[0].cout, sb[0].ovf, sb[0].zero}) begin
            bad++;
            $display("FAIL stall_frozen: got sum=%h c=%b v=%b z=%b want sum=%h c=%b v=%b z=%b",
                     sum, cout, ovf, zero, sb[0].sum, sb[0].cout, sb[0].ovf, sb[0].zero);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(a, b, op, cin));
        sent++;
        pa = $urandom;
        pb = $urandom;
        po = add_op_t'($urandom_range(0, 3));
        pc = 1'($urandom_range(0, 1));
      end
      if (out_valid && out_ready) begin
        n_out++;
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL stall_extra: unexpected result sum=%h", sum); end
        else begin
          ex = sb.pop_front();
          if ({sum, cout, ovf, zero} !== {ex.sum, ex.cout, ex.ovf, ex.zero}) begin
            bad++;
            $display("FAIL stall_result%0d: got sum=%h c=%b v=%b z=%b want sum=%h c=%b v=%b z=%b",
                     n_out, sum, cout, ovf, zero, ex.sum, ex.cout, ex.ovf, ex.zero);
          end
        end
      end
    end
    total++; if (stalls != 3) begin bad++; $display("FAIL stall_cycles: got %0d want 3", stalls); end
    total++; if (n_out != 10) begin bad++; $display("FAIL stall_count: got %0d results want 10", n_out); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL stall_leftover: %0d expected results never seen", sb.size()); end
    sb.delete();
  endtask

  task automatic test_reset_midstream();
    int n_out = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      present(1'b1, $urandom, $urandom, add_op_t'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
      #1;
    end
    @(negedge clk);
    present(1'b0, '0, '0, ADD, 1'b0, 1'b1);
    #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_mid_before: out_valid=%b want 1", out_valid); end
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: out_valid=%b want 0", out_valid); end
    total++; if (sum !== '0) begin bad++; $display("FAIL rst_mid_sum: got %h want 0", sum); end
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_stale%0d: out_valid=%b sum=%h want no result", c, out_valid, sum); end
    end
    @(negedge clk);
    present(1'b1, 32'h0000_0003, 32'h0000_0004, ADD, 1'b0, 1'b1);
    #1;
    if (in_valid && in_ready) sb.push_back('{sum: 32'h0000_0007, cout: 1'b0, ovf: 1'b0, zero: 1'b0});
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      present(1'b0, '0, '0, ADD, 1'b0, 1'b1);
      #1;
      if (out_valid && out_ready) begin
        n_out++;
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL rst_mid_extra: unexpected result sum=%h", sum); end
        else begin
          ex = sb.pop_front();
          if ({sum, cout, ovf, zero} !== {ex.sum, ex.cout, ex.ovf, ex.zero}) begin
            bad++;
            $display("FAIL rst_mid_recover: got sum=%h c=%b v=%b z=%b want sum=%h c=%b v=%b z=%b",
                     sum, cout, ovf, zero, ex.sum, ex.cout, ex.ovf, ex.zero);
          end
        end
      end
    end
    total++; if (n_out != 1) begin bad++; $display("FAIL rst_mid_count: got %0d results want 1", n_out); end
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
